xor_encryptor: RTL

//  Message-level XOR encryptor; produces the ciphertext consumed by the cpu2 XOR decryptor.

---
 rtl/xor_encryptor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/xor_encryptor.sv
// xor_encryptor: message-level XOR encryptor.
// Buffers MSG_LEN plaintext characters and then one key byte, all captured from
// the switches bus. It then streams char ^ key out on display under a
// valid/ready handshake, and pulses done once the last character has gone out.
// Optional feature macro: ROLLING_KEY_EN. When it is defined, the key rotates
// left by one place after every transfer. When it is undefined, the key is
// constant for the whole message.
module xor_encryptor #(
  parameter int WORD_W  = 10,
  parameter int CHAR_W  = 8,
  parameter int MSG_LEN = 8
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic [WORD_W-1:0]          switches,
  input  logic                       load,
  output logic                       ready,
  output logic [WORD_W-1:0]          display,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(MSG_LEN)-1:0] idx,
  output logic                       done
);

  localparam int CNT_W = $clog2(MSG_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    LOAD_CHARS,
    LOAD_KEY,
    SEND,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CHAR_W-1:0]        key_q, key_d;
  logic [CHAR_W-1:0]        msg_q [MSG_LEN];
  logic [CHAR_W-1:0]        msg_d [MSG_LEN];
  logic [WORD_W-1:0]        display_q, display_d;
  logic                     out_valid_q, out_valid_d;
  logic                     done_q, done_d;

  logic [CHAR_W-1:0]        char_in;
  logic [CHAR_W-1:0]        key_step;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     xfer;
  logic                     unused_sw;

  // Rotate a key left by one place within CHAR_W bits.
  function automatic logic [CHAR_W-1:0] rotl1(input logic [CHAR_W-1:0] k);
    return {k[CHAR_W-2:0], k[CHAR_W-1]};
  endfunction

  // Only the low CHAR_W bits of switches carry data; the rest are deliberately dropped.
  assign char_in   = switches[CHAR_W-1:0];
  assign unused_sw = ^switches;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign xfer    = out_valid_q & out_ready;

  // The key used for the following character: rotated when rolling mode is on.
`ifdef ROLLING_KEY_EN
  assign key_step = rotl1(key_q);
`else
  assign key_step = key_q;
`endif

  assign ready     = (state_q == LOAD_CHARS) || (state_q == LOAD_KEY);
  assign display   = display_q;
  assign out_valid = out_valid_q;
  assign idx       = cnt_q;
  assign done      = done_q;

  // Next-state logic: capture chars, capture the key, then stream ciphertext.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    msg_d       = msg_q;
    display_d   = display_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      LOAD_CHARS: begin
        if (load) begin
          msg_d[cnt_q] = char_in;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = LOAD_KEY;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LOAD_KEY: begin
        if (load) begin
          // The first ciphertext char uses the key arriving on this very edge.
          key_d       = char_in;
          display_d   = WORD_W'(msg_q[0] ^ char_in);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          key_d = key_step;
          if (cnt_q == LAST) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            cnt_d       = '0;
            state_d     = DONE;
          end else begin
            cnt_d     = cnt_inc;
            display_d = WORD_W'(msg_q[cnt_inc] ^ key_step);
          end
        end
      end
      DONE: begin
        state_d = LOAD_CHARS;
      end
      default: begin
        state_d = LOAD_CHARS;
      end
    endcase
  end

  // State and datapath registers; reset aborts any message in flight.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= LOAD_CHARS;
      cnt_q       <= '0;
      key_q       <= '0;
      display_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      display_q   <= display_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      msg_q       <= msg_d;
    end
  end

endmodule
